// File: rtl/parallel2sequence.sv
// Purpose : serialise a 32-bit word of four signed 8-bit lanes into bytes, lane0 ([31:24]) first.
// Latency : 1 cycle from input transfer to the first valid byte; sustains 1 byte per cycle.
// Backpres: a one-word pending register lets a new word be taken while a word drains; ready_o
//           drops only when both shift and pending registers hold words.
// Ports   : clk/rst_n (async active-low); data_i/valid_i/ready_o upstream word handshake;
//           data_o/valid_o/ready_i/last_o downstream byte handshake; read_signal = one-cycle
//           registered prefetch request, issued the cycle after lane1 leaves.
module parallel2sequence (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic signed [7:0]  data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               last_o,
    output logic               read_signal
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] sr, sr_nxt;
    logic [31:0] pr, pr_nxt;
    logic [1:0]  idx, idx_nxt;

    logic in_xfer;
    logic out_xfer;
    logic final_out;

    // Handshake outputs are decoded from state alone so no combinational
    // path exists from valid_i/ready_i to ready_o/valid_o.
    assign ready_o   = (state != FULL);
    assign valid_o   = (state != EMPTY);
    assign data_o    = sr[31:24];
    assign last_o    = valid_o && (idx == 2'd3);

    assign in_xfer   = valid_i && ready_o;
    assign out_xfer  = valid_o && ready_i;
    assign final_out = out_xfer && (idx == 2'd3);

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        pr_nxt    = pr;
        idx_nxt   = idx;

        // Non-final byte accepted downstream: advance to the next lane.
        if (out_xfer && !final_out) begin
            sr_nxt  = {sr[23:0], 8'h00};
            idx_nxt = idx + 2'd1;
        end

        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    sr_nxt    = data_i;
                    idx_nxt   = 2'd0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (final_out) begin
                    idx_nxt = 2'd0;
                    if (in_xfer) begin
                        // Reload straight into the shift register: no bubble.
                        sr_nxt    = data_i;
                        state_nxt = BUSY;
                    end else begin
                        sr_nxt    = 32'h0;
                        state_nxt = EMPTY;
                    end
                end else if (in_xfer) begin
                    pr_nxt    = data_i;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                // ready_o is low here, so only the drain side can move.
                if (final_out) begin
                    sr_nxt    = pr;
                    pr_nxt    = 32'h0;
                    idx_nxt   = 2'd0;
                    state_nxt = BUSY;
                end
            end
            default: begin
                state_nxt = EMPTY;
                sr_nxt    = 32'h0;
                pr_nxt    = 32'h0;
                idx_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            sr          <= 32'h0;
            pr          <= 32'h0;
            idx         <= 2'd0;
            read_signal <= 1'b0;
        end else begin
            state       <= state_nxt;
            sr          <= sr_nxt;
            pr          <= pr_nxt;
            idx         <= idx_nxt;
            // Pulse after lane1 is taken so upstream has two byte-times to
            // fetch the next word before the current one finishes.
            read_signal <= out_xfer && (idx == 2'd1);
        end
    end

endmodule

// File: doc/parallel2sequence.md
PARALLEL2SEQUENCE -- requirements
Module: parallel2sequence

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port data_i  input  32  parallel word, four signed 8-bit lanes: [31:24] lane0 .. [7:0] lane3.
REQ-004 SHALL have port valid_i  input  1  data_i valid.
REQ-005 SHALL have port ready_o  output  1  block can accept a word this cycle.
REQ-006 SHALL have port data_o  output  8  signed serial byte.
REQ-007 SHALL have port valid_o  output  1  data_o valid.
REQ-008 SHALL have port ready_i  input  1  downstream accepts data_o this cycle.
REQ-009 SHALL have port last_o  output  1  data_o is lane3, the final byte of the word.
REQ-010 SHALL have port read_signal  output  1  one-cycle prefetch request to the upstream word source.

Function
REQ-011 SHALL count an input transfer when valid_i && ready_o at a rising edge, and an output transfer when valid_o && ready_i.
REQ-012 SHALL hold a 32-bit shift register (SR), a 32-bit pending register (PR), and a 2-bit byte index (idx).
REQ-013 SHALL implement states EMPTY (SR and PR empty), BUSY (SR loaded, PR empty), FULL (SR and PR loaded).
REQ-014 SHALL drive ready_o = (state != FULL) and valid_o = (state != EMPTY), decoded from state only, with no combinational path from valid_i or ready_i.
REQ-015 SHALL drive data_o = SR[31:24] and last_o = valid_o && (idx == 3).
REQ-016 SHALL emit lanes in order lane0, lane1, lane2, lane3, one byte per output transfer, and SHALL NOT reorder or modify any byte.
REQ-017 SHALL handle transitions from EMPTY: input transfer -> SR = data_i, idx = 0, go to BUSY.
REQ-018 SHALL handle non-final output transfers (idx < 3): SR shifts left 8 bits, idx increments, state unchanged apart from any concurrent input handling.
REQ-019 SHALL, in BUSY with an input transfer and no final-byte output transfer, load PR = data_i and go to FULL.
REQ-020 SHALL, in BUSY with a final-byte output transfer and a simultaneous input transfer, load SR = data_i, set idx = 0 and stay in BUSY, with no bubble.
REQ-021 SHALL, in BUSY with a final-byte output transfer and no input transfer, go to EMPTY with idx = 0.
REQ-022 SHALL, in FULL with a final-byte output transfer, move SR = PR, set idx = 0 and go to BUSY; no input transfer is possible in FULL.
REQ-023 SHALL hold SR, PR, idx and data_o stable while valid_o && !ready_i (output stall).
REQ-024 SHALL drive read_signal high for exactly one cycle, registered, in the cycle after the output transfer of lane1; it SHALL stay 0 otherwise, including during stalls.
REQ-025 SHALL give a minimum latency of 1 cycle from input transfer to the first valid_o of a word, and SHALL sustain a throughput of 1 byte per cycle.

Reset
REQ-026 SHALL, on rst_n low, immediately force: state EMPTY, SR = 0, PR = 0, idx = 0, read_signal = 0; hence ready_o = 1, valid_o = 0, last_o = 0, data_o = 8'h00.
REQ-027 SHALL, on reset asserted mid-word, discard all buffered bytes, and SHALL emit no partial word after rst_n deasserts.

Verification
REQ-028 SHALL cover single word: data_i = 32'h80_7F_01_FF, ready_i held 1 -> data_o sequence 80, 7F, 01, FF on 4 consecutive cycles; last_o only with FF; read_signal pulses one cycle after 7F is sent.
REQ-029 SHALL cover back-to-back: words 32'h11223344 and 32'h55667788 with valid_i held 1 -> 8 contiguous bytes 11..88 with no gap; ready_o drops for exactly the cycles the block is in FULL.
REQ-030 SHALL cover stall: ready_i = 0 for 5 cycles while lane2 = 8'hAB is presented -> data_o stays AB, idx stays unchanged, no read_signal; resumes correctly when ready_i = 1.
REQ-031 SHALL cover full: two words accepted while ready_i = 0 -> ready_o = 0; a third valid_i is not accepted, and that word is later sent only after a fresh handshake.
REQ-032 SHALL cover reset mid-word: rst_n pulsed low after 2 of 4 bytes -> outputs take reset values at once; next word 32'hDEADBEEF emits DE, AD, BE, EF.
REQ-033 SHALL cover random: randomized valid_i/ready_i over 1000 words against a byte-queue scoreboard -> zero mismatches, and a last_o count equal to the word count.
